// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : controller states (IDLE, RUN, DONE)
//   SUB_WIDTH : default operand/result width
//   cnt_width : bit-counter width for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH = 4;

  // Width of the bit counter: enough to hold 0..w-1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - br_in.
// Ports:
//   a, b    : operand bits
//   br_in   : incoming borrow
//   d       : difference bit
//   br_out  : outgoing borrow
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - b_in, one bit per clock, LSB first,
// through a single shared full_subtractor cell.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow port ovf.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   start       : request; accepted in IDLE or DONE, ignored in RUN
//   a, b, b_in  : operands, captured when start is accepted
//   busy        : high while bits are being processed (RUN)
//   done        : one-cycle pulse, d/b_out (and ovf) hold the new result
//   d           : difference register
//   b_out       : per-stage borrow vector; b_out[WIDTH-1] is the final borrow
//   ovf         : two's-complement overflow (SERIAL_SUB_OVF_EN only)
// Handshake: start is a level sampled on every rising edge; it is taken when
// the controller is in IDLE or DONE and dropped on the floor in RUN. done
// pulses for exactly one cycle per accepted start and never overlaps busy.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [WIDTH-1:0] d_acc;
  logic [WIDTH-1:0] bo_acc;

  logic             fs_a;
  logic             fs_b;
  logic             fs_br_in;
  logic             fs_d;
  logic             fs_br_out;
  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] bo_next;

  // In RUN the cell works on the shift-register LSBs. In DONE the cell is fed
  // straight from the inputs so a back-to-back request processes its bit 0 on
  // the same edge that captures it, giving one result every WIDTH cycles.
  always_comb begin
    fs_a     = a[0];
    fs_b     = b[0];
    fs_br_in = b_in;
    bit_idx  = '0;
    d_next   = '0;
    bo_next  = '0;
    if (state == RUN) begin
      fs_a     = a_sr[0];
      fs_b     = b_sr[0];
      fs_br_in = br;
      bit_idx  = counter;
      d_next   = d_acc;
      bo_next  = bo_acc;
    end
    d_next[bit_idx]  = fs_d;
    bo_next[bit_idx] = fs_br_out;
  end

  full_subtractor u_cell (
    .a      (fs_a),
    .b      (fs_b),
    .br_in  (fs_br_in),
    .d      (fs_d),
    .br_out (fs_br_out)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      counter <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      br      <= 1'b0;
      d_acc   <= '0;
      bo_acc  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= '0;
      b_out   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            br      <= b_in;
            counter <= '0;
            d_acc   <= '0;
            bo_acc  <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          br      <= fs_br_out;
          d_acc   <= d_next;
          bo_acc  <= bo_next;
          counter <= counter + CW'(1);
          if (counter == LAST) begin
            counter <= '0;
            d       <= d_next;
            b_out   <= bo_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= bo_next[WIDTH-1] ^ bo_next[WIDTH-2];
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            // Capture and process bit 0 in one step (see the cell mux above).
            a_sr    <= a >> 1;
            b_sr    <= b >> 1;
            br      <= fs_br_out;
            d_acc   <= d_next;
            bo_acc  <= bo_next;
            counter <= CW'(1);
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4). Results are compared
// against an arithmetic model (plain integer subtraction and prefix compares).
// Optional feature macro: SERIAL_SUB_OVF_EN (ovf port and its checks).
module tb_serial_subtractor;

  localparam int W = 4;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic [W-1:0] b_out;
  logic         ovf_s;

  always #5 clk = ~clk;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  assign ovf_s = ovf;
`else
  assign ovf_s = 1'b0;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .a      (a),
    .b      (b),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .d      (d),
    .b_out  (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {ovf, b_out, d}
  logic [2*W:0] exp_q[$];
  logic [2*W:0] last_exp;
  int n_checks = 0;
  int n_fails  = 0;

  function automatic logic [2*W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mbin);
    int diff, sa, sb, sd, mask;
    logic [31:0] diff_v;
    logic [W-1:0] md, mbo;
    logic mo;
    diff   = int'(ma) - int'(mb) - int'(mbin);
    diff_v = diff;
    md     = diff_v[W-1:0];
    for (int i = 0; i < W; i++) begin
      mask   = (1 << (i + 1)) - 1;
      mbo[i] = ((int'(ma) & mask) < ((int'(mb) & mask) + int'(mbin)));
    end
    sa = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
    sb = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
    sd = sa - sb - int'(mbin);
    mo = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    return {mo & OVF_EN, mbo, md};
  endfunction

  // ---------------- driver tasks ----------------
  // One full operation: pulse start, wait for done (bounded), sample result.
  // lat counts negedges after the accepting edge until done is seen (-1 = timeout).
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        output int lat, output int bcnt, output logic [2*W:0] got,
                        output logic busy_at_done, output logic done_after);
    @(negedge clk);
    a = ia; b = ib; b_in = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) lat = -1;
    got          = {ovf_s, b_out, d};
    busy_at_done = busy;
    @(negedge clk);
    done_after = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++;
      if (d !== '0) begin n_fails++; $display("FAIL reset_d: got %b want 0000", d); end
      n_checks++;
      if (b_out !== '0) begin n_fails++; $display("FAIL reset_b_out: got %b want 0000", b_out); end
      n_checks++;
      if (ovf_s !== 1'b0) begin n_fails++; $display("FAIL reset_ovf: got %b want 0", ovf_s); end
      resetn = 1'b1;
      @(negedge clk);
    end
    last_exp = '0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4], tb_v[4], td[4], tbo[4];
    logic         tbin[4], tov[4];
    int lat, bcnt;
    logic [2*W:0] got, exp;
    logic bad, da;
    ta  = '{4'b0111, 4'b0011, 4'b0000, 4'b1000};
    tb_v = '{4'b0011, 4'b0101, 4'b0000, 4'b0001};
    tbin = '{1'b0, 1'b0, 1'b1, 1'b0};
    td  = '{4'b0100, 4'b1110, 4'b1111, 4'b0111};
    tbo = '{4'b0000, 4'b1100, 4'b1111, 4'b0111};
    tov = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp = {tov[i] & OVF_EN, tbo[i], td[i]};
      run_op(ta[i], tb_v[i], tbin[i], lat, bcnt, got, bad, da);
      n_checks++;
      if (lat != W) begin n_fails++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W); end
      n_checks++;
      if (bcnt != W) begin n_fails++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bcnt, W); end
      n_checks++;
      if (got !== exp) begin n_fails++; $display("FAIL dir%0d_result: got %b want %b", i, got, exp); end
      n_checks++;
      if (bad !== 1'b0) begin n_fails++; $display("FAIL dir%0d_busy_with_done: got %b want 0", i, bad); end
      n_checks++;
      if (da !== 1'b0) begin n_fails++; $display("FAIL dir%0d_done_pulse_width: got %b want 0", i, da); end
      last_exp = exp;
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [2*W:0] got, exp;
    logic bad, da;
    logic [W-1:0] ra, rb;
    logic rbin;
    for (int i = 0; i < 24; i++) begin
      ra   = W'($urandom_range(0, (1 << W) - 1));
      rb   = W'($urandom_range(0, (1 << W) - 1));
      rbin = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rbin));
      run_op(ra, rb, rbin, lat, bcnt, got, bad, da);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL rand%0d_result a=%b b=%b bin=%b: got %b want %b", i, ra, rb, rbin, got, exp);
      end
      n_checks++;
      if (lat != W) begin n_fails++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, W); end
      last_exp = exp;
    end
  endtask

  task automatic test_start_in_run();
    int n_done;
    logic [2*W:0] got, exp;
    exp = model(4'b1010, 4'b0110, 1'b1);
    @(negedge clk);
    a = 4'b1010; b = 4'b0110; b_in = 1'b1; start = 1'b1;
    @(negedge clk);                       // after accepting edge
    start = 1'b0;
    @(negedge clk);                       // one bit processed
    n_checks++;
    if ({ovf_s, b_out, d} !== last_exp) begin
      n_fails++;
      $display("FAIL run_hold_prev_result: got %b want %b", {ovf_s, b_out, d}, last_exp);
    end
    a = 4'b0001; b = 4'b1111; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    got = '0;
    for (int c = 0; c < 15; c++) begin
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) got = {ovf_s, b_out, d};
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_done != 1) begin n_fails++; $display("FAIL run_ignore_done_count: got %0d want 1", n_done); end
    n_checks++;
    if (got !== exp) begin n_fails++; $display("FAIL run_ignore_result: got %b want %b", got, exp); end
    last_exp = exp;
  endtask

  task automatic test_reset_mid_run();
    int n_done, lat, bcnt;
    logic [2*W:0] got, exp;
    logic bad, da;
    @(negedge clk);
    a = 4'b1100; b = 4'b0101; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);            // two bits processed
    resetn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++;
    if ({ovf_s, b_out, d} !== '0) begin
      n_fails++;
      $display("FAIL abort_outputs: got %b want 0", {ovf_s, b_out, d});
    end
    @(negedge clk);
    resetn = 1'b1;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    n_checks++;
    if (n_done != 0) begin n_fails++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
    exp = model(4'b1001, 4'b0011, 1'b1);
    run_op(4'b1001, 4'b0011, 1'b1, lat, bcnt, got, bad, da);
    n_checks++;
    if (got !== exp) begin n_fails++; $display("FAIL abort_restart_result: got %b want %b", got, exp); end
    n_checks++;
    if (lat != W) begin n_fails++; $display("FAIL abort_restart_latency: got %0d want %0d", lat, W); end
    last_exp = exp;
  endtask

  task automatic test_back_to_back();
    int cyc, gap;
    logic [2*W:0] got1, got2, exp1, exp2;
    @(negedge clk);
    a = 4'b1000; b = 4'b0001; b_in = 1'b0; start = 1'b1;
    exp_q.push_back(model(4'b1000, 4'b0001, 1'b0));
    @(negedge clk);                       // first accepted; start stays high
    a = 4'b0010; b = 4'b0111; b_in = 1'b1;
    exp_q.push_back(model(4'b0010, 4'b0111, 1'b1));
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    got1 = {ovf_s, b_out, d};
    @(negedge clk);                       // second accepted from DONE
    start = 1'b0;
    gap = 1;
    while (done !== 1'b1 && gap < 40) begin @(negedge clk); gap++; end
    got2 = {ovf_s, b_out, d};
    exp1 = exp_q.pop_front();
    exp2 = exp_q.pop_front();
    n_checks++;
    if (cyc != W) begin n_fails++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc, W); end
    n_checks++;
    if (got1 !== exp1) begin n_fails++; $display("FAIL b2b_first_result: got %b want %b", got1, exp1); end
    n_checks++;
    if (gap != W) begin n_fails++; $display("FAIL b2b_done_gap: got %0d want %0d", gap, W); end
    n_checks++;
    if (got2 !== exp2) begin n_fails++; $display("FAIL b2b_second_result: got %b want %b", got2, exp2); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_return_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    last_exp = exp2;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
